// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter serialising per-core read/write
// requests onto one synchronous single-port data RAM (1-cycle read latency).
// Each access takes three cycles: IDLE (arbitrate), BUSY (RAM access),
// ACK (one-cycle acknowledge with read data).

module shared_mem_arbiter #(
   parameter int CORE_COUNT = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CORE_COUNT-1:0]            req,
   input  logic [CORE_COUNT-1:0]            wrEn,
   input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr,
   input  logic [CORE_COUNT*DATA_WIDTH-1:0] wrData,
   output logic [CORE_COUNT-1:0]            grant,
   output logic [CORE_COUNT-1:0]            ack,
   output logic [DATA_WIDTH-1:0]            rdData,
   output logic                             busy,
   output logic [ADDR_WIDTH-1:0]            memAddr,
   output logic [DATA_WIDTH-1:0]            memWrData,
   output logic                             memWrEn,
   input  logic [DATA_WIDTH-1:0]            memRdData
);

   localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CORE_COUNT-1:0]   grant_q, grant_d;
   logic [CORE_COUNT-1:0]   ack_q, ack_d;
   logic                    busy_q, busy_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
   logic                    mem_wr_en_q, mem_wr_en_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic [IDX_W-1:0]        last_grant_q, last_grant_d;
   logic                    is_wr_q, is_wr_d;

   logic [ADDR_WIDTH-1:0]   addr_arr_s   [CORE_COUNT];
   logic [DATA_WIDTH-1:0]   wr_data_arr_s [CORE_COUNT];
   logic [IDX_W-1:0]        winner_s;
   logic                    found_s;

   // Unpack the flat per-core address and write-data buses into arrays.
   always_comb begin
      for (int i = 0; i < CORE_COUNT; i++) begin
         addr_arr_s[i]    = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         wr_data_arr_s[i] = wrData[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin pick: first requester scanning upward from lastGrant+1.
   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      logic [IDX_W-1:0] cand;
      found_s  = |req;
      winner_s = last_grant_q;
      for (int off = CORE_COUNT; off >= 1; off--) begin
         cand     = IDX_W'((int'(last_grant_q) + off) % CORE_COUNT);
         winner_s = req[cand] ? cand : winner_s;
      end
   end

   // Next-state and next-output computation for the access FSM.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ack_d         = ack_q;
      busy_d        = busy_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      mem_wr_en_d   = mem_wr_en_q;
      rd_data_d     = rd_data_q;
      last_grant_d  = last_grant_q;
      is_wr_d       = is_wr_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d       = ST_BUSY;
               mem_addr_d    = addr_arr_s[winner_s];
               mem_wr_data_d = wr_data_arr_s[winner_s];
               mem_wr_en_d   = wrEn[winner_s];
               is_wr_d       = wrEn[winner_s];
               grant_d       = {{(CORE_COUNT-1){1'b0}}, 1'b1} << winner_s;
               last_grant_d  = winner_s;
               busy_d        = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // RAM performs the access on this edge; the write strobe ends here.
            mem_wr_en_d = 1'b0;
            ack_d       = grant_q;
            state_d     = ST_ACK;
         end
         ST_ACK: begin
            ack_d   = {CORE_COUNT{1'b0}};
            grant_d = {CORE_COUNT{1'b0}};
            busy_d  = 1'b0;
            if (!is_wr_q) begin
               rd_data_d = memRdData;
            end else begin
               rd_data_d = rd_data_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            grant_d     = {CORE_COUNT{1'b0}};
            ack_d       = {CORE_COUNT{1'b0}};
            busy_d      = 1'b0;
            mem_wr_en_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset is asynchronous so an in-flight
   // write is aborted immediately by dropping memWrEn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= {CORE_COUNT{1'b0}};
         ack_q         <= {CORE_COUNT{1'b0}};
         busy_q        <= 1'b0;
         mem_addr_q    <= {ADDR_WIDTH{1'b0}};
         mem_wr_data_q <= {DATA_WIDTH{1'b0}};
         mem_wr_en_q   <= 1'b0;
         rd_data_q     <= {DATA_WIDTH{1'b0}};
         last_grant_q  <= IDX_W'(CORE_COUNT - 1);
         is_wr_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         busy_q        <= busy_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         mem_wr_en_q   <= mem_wr_en_d;
         rd_data_q     <= rd_data_d;
         last_grant_q  <= last_grant_d;
         is_wr_q       <= is_wr_d;
      end
   end

   assign grant     = grant_q;
   assign ack       = ack_q;
   assign busy      = busy_q;
   assign memAddr   = mem_addr_q;
   assign memWrData = mem_wr_data_q;
   assign memWrEn   = mem_wr_en_q;
   // Read data is forwarded straight from the RAM in the ACK cycle of a read
   // and held in rd_data_q afterwards.
   assign rdData    = (state_q == ST_ACK && !is_wr_q) ? memRdData : rd_data_q;

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Round-robin arbiter that shares one synchronous single-port data memory between the `CORE_COUNT` processing cores of the multicore processor. Each core's control unit raises a read or write request, which the arbiter serialises onto the memory port. The arbiter returns a one-cycle acknowledge with read data to the winning core. The block sits between the per-core data-memory interfaces and the shared data RAM, which has a 1-cycle read latency.

## Interface
- `CORE_COUNT`, 4, number of requesting cores (2..8)
- `ADDR_WIDTH`, 12, data-memory address width
- `DATA_WIDTH`, 12, data-memory word width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  CORE_COUNT  per-core access request, level, held until `ack`
- `wrEn`  in  CORE_COUNT  per-core access type, 1 = write, 0 = read; valid while `req` is high
- `addr`  in  CORE_COUNT*ADDR_WIDTH  packed addresses, core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `wrData`  in  CORE_COUNT*DATA_WIDTH  packed write data, packed the same way
- `grant`  out  CORE_COUNT  one-hot, identifies the core currently being served; 0 when idle
- `ack`  out  CORE_COUNT  one-hot, one-cycle completion pulse to the served core
- `rdData`  out  DATA_WIDTH  read data, valid in the `ack` cycle of a read
- `busy`  out  1  high while in BUSY or ACK
- `memAddr`  out  ADDR_WIDTH  RAM address (registered)
- `memWrData`  out  DATA_WIDTH  RAM write data (registered)
- `memWrEn`  out  1  RAM write enable (registered)
- `memRdData`  in  DATA_WIDTH  RAM read data, valid one cycle after the address is presented

## Operation
- FSM states: IDLE, BUSY, ACK.
- **IDLE:** if `req` is nonzero, select a winner and go to BUSY. Otherwise stay in IDLE.
  - Winner is the first set `req` bit, scanning from index `lastGrant+1` upward with wrap-around modulo `CORE_COUNT`.
  - On the IDLE->BUSY edge, register the winner's `addr` into `memAddr`, its `wrData` into `memWrData`, and its `wrEn` into `memWrEn`.
  - On the same edge, set `grant` to the winner's one-hot value, set `lastGrant` to the winner index, and set `busy` to 1.
- **BUSY:** the RAM performs the access on the edge that ends this cycle. On that edge, clear `memWrEn` and go to ACK.
- **ACK:**
  - `ack[winner]` = 1 for exactly this cycle.
  - For reads, `rdData` = `memRdData`, captured combinationally and also registered so it holds until the next ACK.
  - For writes, `rdData` is unchanged.
  - Next state is IDLE, where `grant` and `busy` are cleared.
- `lastGrant` resets to `CORE_COUNT-1`, so core 0 has top priority after reset.
- Requester rule: a core keeps `req`, `wrEn`, `addr` and `wrData` stable until it samples `ack`, and it drops `req` in the cycle after `ack`.
  - The arbiter samples inputs only in IDLE. Changes during BUSY or ACK have no effect.
- A `req` withdrawn after it has been granted is a protocol violation. The access still completes and `ack` is still pulsed.
- Writes never return data. Reads never assert `memWrEn`.
- Out-of-range addresses do not exist: `addr` is taken modulo 2^ADDR_WIDTH by width.

## Timing
- Reset values: `grant`=0, `ack`=0, `busy`=0, `memWrEn`=0, `memAddr`=0, `memWrData`=0, `rdData`=0, state=IDLE, `lastGrant`=CORE_COUNT-1.
- Asserting `rst` mid-access clears all outputs immediately, without waiting for a clock.
  - A write in BUSY is aborted because `memWrEn` drops asynchronously.
  - No `ack` is issued for the aborted access.
- Latency: `req` is seen in IDLE at cycle n. `memAddr`/`memWrEn` are valid in cycle n+1. `ack`/`rdData` are valid in cycle n+2.
- Throughput: one access per 3 cycles. The next IDLE arbitration happens at n+3, where the acked core's `req` is already low.
- Simultaneous requests: exactly one grant per arbitration, never two `ack` bits in one cycle.
- Fairness: a continuously requesting core waits at most `CORE_COUNT-1` other accesses, i.e. at most 3*(CORE_COUNT-1) cycles before its own grant.

## Test plan
All scenarios use CORE_COUNT=4, ADDR_WIDTH=12, DATA_WIDTH=12, with a behavioural 1-cycle-latency RAM model.
- **Single write then read:** core 2 writes 0x5A3 to address 0x010, then reads 0x010.
  - `memWrEn` is high for one cycle with `memAddr`=0x010.
  - `ack` = 4'b0100 at n+2 for both accesses.
  - `rdData` = 0x5A3 in the read's `ack` cycle.
- **All four request together after reset:** each core reads a distinct preloaded address. Grants go to core 0, 1, 2, 3 in that order. Each `ack` is 3 cycles apart, and each `rdData` matches its address.
- **Wrap-around round-robin:** after core 3 is served, cores 0 and 3 request together. Core 0 is granted first, then core 3.
- **Starvation check:** cores 0 and 1 re-request immediately after every `ack` for 20 accesses. Grants alternate 0, 1, 0, 1 and never serve one core twice in a row.
- **Reset during BUSY:** core 1 writes 0xFFF to 0x020 with `rst` pulsed in the BUSY cycle.
  - `memWrEn` falls without waiting for a clock and the RAM word keeps its old value.
  - No `ack` is issued, and all outputs equal their reset values.
- **Input change during access:** core 0 changes `addr` from 0x030 to 0x031 during BUSY. `memAddr` stays 0x030, and the read returns the contents of 0x030.
